// File: rtl/pe_acc_ctrl_if.sv
// Operand and result stream bundle for pe_acc_ctrl.
// The master drives operands and result acceptance; the slave (controller) returns ready/result.
interface pe_acc_ctrl_if #(
  parameter int unsigned INP_WIDTH = 8,
  parameter int unsigned WGT_WIDTH = 8,
  parameter int unsigned OUT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [INP_WIDTH-1:0] in_inp;
  logic [WGT_WIDTH-1:0] in_wgt;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_inp, in_wgt, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_inp, in_wgt, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pe_acc_ctrl.sv
// Accumulate/drain controller around one combinational MAC: accumulates cfg_len products,
// then shifts, clips and presents one result. Define PE_ACC_ROUND_EN for round-half-up shifting.
module pe_acc_ctrl #(
  parameter int unsigned INP_WIDTH = 8,
  parameter int unsigned WGT_WIDTH = 8,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned SHF_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CNT_WIDTH-1:0] cfg_len,
  input  logic [SHF_WIDTH-1:0] cfg_shift,
  pe_acc_ctrl_if.slave         bus,
  output logic [INP_WIDTH-1:0] mac_inp,
  output logic [WGT_WIDTH-1:0] mac_wgt,
  output logic [ACC_WIDTH-1:0] mac_acc,
  input  logic [ACC_WIDTH-1:0] mac_sum,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

  localparam logic signed [ACC_WIDTH-1:0] OutMax =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OutMin = ~OutMax;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [SHF_WIDTH-1:0] shf_q, shf_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;

  logic                        accept, drain;
  logic [CNT_WIDTH-1:0]        len_eff;
  logic [SHF_WIDTH-1:0]        shf_eff;
  logic signed [ACC_WIDTH-1:0] biased, shifted;
  logic [OUT_WIDTH-1:0]        clipped;

  assign bus.in_ready  = (state_q != StDrain);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q != StIdle);

  assign accept = bus.in_valid & bus.in_ready;
  assign drain  = out_valid_q & bus.out_ready;

  assign mac_inp = bus.in_inp;
  assign mac_wgt = bus.in_wgt;
  assign mac_acc = (state_q == StIdle) ? '0 : acc_q;

  assign len_eff = (cfg_len == '0) ? CNT_WIDTH'(1) : cfg_len;
  // A single-product tile drains straight from idle, before shf_q holds the new shift.
  assign shf_eff = (state_q == StIdle) ? cfg_shift : shf_q;

`ifdef PE_ACC_ROUND_EN
  assign biased = (shf_eff != '0) ? $signed(mac_sum + (ACC_WIDTH'(1) << (shf_eff - 1'b1)))
                                  : $signed(mac_sum);
`else
  assign biased = $signed(mac_sum);
`endif

  assign shifted = biased >>> shf_eff;

  always_comb begin
    clipped = shifted[OUT_WIDTH-1:0];
    if (shifted > OutMax) begin
      clipped = OutMax[OUT_WIDTH-1:0];
    end else if (shifted < OutMin) begin
      clipped = OutMin[OUT_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    shf_d       = shf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          len_d = len_eff;
          shf_d = cfg_shift;
          acc_d = mac_sum;
          cnt_d = CNT_WIDTH'(1);
          if (len_eff == CNT_WIDTH'(1)) begin
            out_valid_d = 1'b1;
            out_data_d  = clipped;
            state_d     = StDrain;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StAccum: begin
        if (accept) begin
          acc_d = mac_sum;
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_q == len_q - CNT_WIDTH'(1)) begin
            out_valid_d = 1'b1;
            out_data_d  = clipped;
            state_d     = StDrain;
          end
        end
      end
      StDrain: begin
        if (drain) begin
          out_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      shf_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      shf_q       <= shf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_pe_acc_ctrl.sv
// Directed bench for pe_acc_ctrl with a behavioural MAC; expectations follow PE_ACC_ROUND_EN.
module tb_pe_acc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_len;
  logic [4:0]  cfg_shift;
  logic [7:0]  mac_inp, mac_wgt;
  logic [31:0] mac_acc, mac_sum;
  logic        busy;

  int total = 0;
  int bad   = 0;

  pe_acc_ctrl_if #(.INP_WIDTH(8), .WGT_WIDTH(8), .OUT_WIDTH(8)) bus ();

  pe_acc_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_len   (cfg_len),
    .cfg_shift (cfg_shift),
    .bus       (bus),
    .mac_inp   (mac_inp),
    .mac_wgt   (mac_wgt),
    .mac_acc   (mac_acc),
    .mac_sum   (mac_sum),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic signed [31:0] inp_x, wgt_x;
  assign inp_x   = {{24{mac_inp[7]}}, mac_inp};
  assign wgt_x   = {{24{mac_wgt[7]}}, mac_wgt};
  assign mac_sum = inp_x * wgt_x + mac_acc;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic signed [7:0] inp, input logic signed [7:0] wgt);
    bus.in_valid = 1'b1;
    bus.in_inp   = inp;
    bus.in_wgt   = wgt;
    tick();
  endtask

  initial begin
    rst_n         = 1'b0;
    cfg_len       = 16'd1;
    cfg_shift     = 5'd0;
    bus.in_valid  = 1'b0;
    bus.in_inp    = '0;
    bus.in_wgt    = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    // Tile of four: 1+2+3+4
    cfg_len = 16'd4;
    for (int i = 1; i <= 4; i++) begin
      drive(8'(i), 8'sd1);
      if (i == 3) chk("t1_no_early_valid", 32'(bus.out_valid), 0);
    end
    bus.in_valid = 1'b0;
    chk("t1_out_valid", 32'(bus.out_valid), 1);
    chk("t1_out_data", $signed(bus.out_data), 10);
    chk("t1_in_ready_drain", 32'(bus.in_ready), 0);
    chk("t1_busy", 32'(busy), 1);
    tick();
    chk("t1_drained", 32'(bus.out_valid), 0);
    chk("t1_in_ready_back", 32'(bus.in_ready), 1);

    // Clipping at both rails
    cfg_len = 16'd2;
    drive(8'sd127, 8'sd127);
    drive(8'sd127, 8'sd127);
    bus.in_valid = 1'b0;
    chk("t2_clip_hi", $signed(bus.out_data), 127);
    tick();
    cfg_len = 16'd1;
    drive(-8'sd128, 8'sd127);
    bus.in_valid = 1'b0;
    chk("t2_clip_lo", $signed(bus.out_data), -128);
    tick();

    // Shift with and without rounding
    cfg_shift = 5'd4;
    drive(8'sd104, 8'sd1);
    bus.in_valid = 1'b0;
`ifdef PE_ACC_ROUND_EN
    chk("t3_shift_104", $signed(bus.out_data), 7);
`else
    chk("t3_shift_104", $signed(bus.out_data), 6);
`endif
    tick();
    drive(8'sd100, 8'sd1);
    bus.in_valid = 1'b0;
    chk("t3_shift_100", $signed(bus.out_data), 6);
    tick();
    cfg_shift = 5'd0;

    // Backpressure: held result while new operands wait
    bus.out_ready = 1'b0;
    drive(8'sd5, 8'sd3);
    bus.in_inp = 8'sd2;
    bus.in_wgt = 8'sd2;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(bus.out_valid), 1);
      chk("t4_hold_data", $signed(bus.out_data), 15);
      chk("t4_hold_ready", 32'(bus.in_ready), 0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("t4_release_ready", 32'(bus.in_ready), 1);
    chk("t4_release_valid", 32'(bus.out_valid), 0);
    tick();
    bus.in_valid = 1'b0;
    chk("t4_next_valid", 32'(bus.out_valid), 1);
    chk("t4_next_data", $signed(bus.out_data), 4);
    tick();

    // Asynchronous reset mid-tile
    cfg_len = 16'd4;
    drive(8'sd7, 8'sd7);
    drive(8'sd7, 8'sd7);
    bus.in_valid = 1'b0;
    chk("t5_busy_before", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_busy", 32'(busy), 0);
    chk("t5_async_valid", 32'(bus.out_valid), 0);
    chk("t5_async_data", 32'(bus.out_data), 0);
    chk("t5_async_mac_acc", 32'(mac_acc), 0);
    tick();
    rst_n = 1'b1;
    tick();
    cfg_len = 16'd2;
    drive(8'sd5, 8'sd5);
    drive(8'sd1, 8'sd1);
    bus.in_valid = 1'b0;
    chk("t5_fresh_valid", 32'(bus.out_valid), 1);
    chk("t5_fresh_data", $signed(bus.out_data), 26);
    tick();

    // Zero length is a single-product tile
    cfg_len = 16'd0;
    bus.out_ready = 1'b0;
    drive(8'sd3, -8'sd2);
    bus.in_valid = 1'b0;
    chk("t6_valid", 32'(bus.out_valid), 1);
    chk("t6_data", $signed(bus.out_data), -6);
    chk("t6_busy", 32'(busy), 1);
    tick();
    chk("t6_busy_hold", 32'(busy), 1);
    bus.out_ready = 1'b1;
    tick();
    chk("t6_busy_done", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
